// File: rtl/pdm_modulator_if.sv
// PCM sample handshake into the PDM modulator.
// The master drives samples; the modulator is the slave.
interface pdm_modulator_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] pcm_data;
    logic              pcm_valid;
    logic              pcm_ready;

    modport master (
        output pcm_data,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  pcm_data,
        input  pcm_valid,
        output pcm_ready
    );
endinterface

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta PCM to PDM modulator.
// Includes bit clock divider, 2-deep sample FIFO and underrun flag.
module pdm_modulator #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int OSR     = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    pdm_modulator_if.slave pcm,
    output logic           pdm_clk,
    output logic           pdm_data,
    output logic           underrun
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(OSR);
    localparam int IW = DATA_W + 4;
    localparam int SW = IW + 2;

    typedef logic signed [IW-1:0] int_t;
    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t FB_POS = sum_t'(2 ** (DATA_W - 1));
    localparam sum_t LIM    = sum_t'(2 ** (DATA_W + 2));

    logic [DW-1:0]            div;
    logic [DW-1:0]            div_n;
    logic                     div_last;
    logic [BW-1:0]            bitcnt;
    logic                     tick;
    logic                     frame;

    logic [DATA_W-1:0]        mem [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               count;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;

    logic signed [DATA_W-1:0] cur_sample;
    logic signed [DATA_W-1:0] x;
    int_t                     i1;
    int_t                     i2;
    int_t                     i1_n;
    int_t                     i2_n;
    sum_t                     fb;
    sum_t                     s1;
    sum_t                     s2;

    function automatic int_t sat(input sum_t v);
        if (v > LIM) begin
            return int_t'(LIM);
        end else if (v < -LIM) begin
            return int_t'(-LIM);
        end
        return int_t'(v);
    endfunction

    assign div_last = (div == DW'(CLK_DIV - 1));
    assign div_n    = div_last ? '0 : div + 1'b1;
    assign tick     = enable && div_last;
    assign frame    = tick && (bitcnt == '0);

    assign full          = (count == 2'd2);
    assign empty         = (count == 2'd0);
    assign pcm.pcm_ready = !full;
    assign push          = pcm.pcm_valid && !full;
    // pop uses pre-push occupancy, so a same-cycle push never bypasses
    assign pop           = frame && !empty;
    assign underrun      = frame && empty;

    always_comb begin
        x = cur_sample;
        if (frame) begin
            x = pop ? $signed(mem[rd_ptr]) : '0;
        end
    end

    always_comb begin
        fb   = pdm_data ? FB_POS : -FB_POS;
        s1   = sum_t'(i1) + sum_t'(x) - fb;
        i1_n = sat(s1);
        s2   = sum_t'(i2) + sum_t'(i1_n) - fb;
        i2_n = sat(s2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pcm.pcm_data;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            bitcnt     <= '0;
            cur_sample <= '0;
            i1         <= '0;
            i2         <= '0;
            pdm_clk    <= 1'b0;
            pdm_data   <= 1'b0;
        end else if (!enable) begin
            div        <= '0;
            bitcnt     <= '0;
            cur_sample <= '0;
            i1         <= '0;
            i2         <= '0;
            pdm_clk    <= 1'b0;
            pdm_data   <= 1'b0;
        end else begin
            div     <= div_n;
            pdm_clk <= (div_n >= DW'(CLK_DIV / 2));
            if (tick) begin
                bitcnt   <= bitcnt + 1'b1;
                i1       <= i1_n;
                i2       <= i2_n;
                pdm_data <= !i2_n[IW-1];
                if (frame) begin
                    cur_sample <= x;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator at DATA_W=16, CLK_DIV=4, OSR=64.
// Scenario tasks check their own expectations inline.
module tb_pdm_modulator;

    logic clk;
    logic rst_n;
    logic enable;
    logic pdm_clk;
    logic pdm_data;
    logic underrun;

    int total;
    int bad;

    pdm_modulator_if #(.DATA_W(16)) pcm_if ();

    pdm_modulator #(
        .DATA_W (16),
        .CLK_DIV(4),
        .OSR    (64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .pcm     (pcm_if),
        .pdm_clk (pdm_clk),
        .pdm_data(pdm_data),
        .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        enable           = 1'b0;
        pcm_if.pcm_valid = 1'b0;
        pcm_if.pcm_data  = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        enable           = 1'b0;
        pcm_if.pcm_valid = 1'b0;
        pcm_if.pcm_data  = 16'h0000;
        #1;
        total += 4;
        if (pdm_clk !== 1'b0) begin
            bad++;
            $display("FAIL rst_pdm_clk: got %b want 0", pdm_clk);
        end
        if (pdm_data !== 1'b0) begin
            bad++;
            $display("FAIL rst_pdm_data: got %b want 0", pdm_data);
        end
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL rst_underrun: got %b want 0", underrun);
        end
        if (pcm_if.pcm_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready: got %b want 1", pcm_if.pcm_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (pdm_clk !== 1'b0 || pdm_data !== 1'b0 ||
                underrun !== 1'b0 || pcm_if.pcm_ready !== 1'b1) begin
                bad++;
                $display("FAIL idle_%0d: got clk=%b data=%b ur=%b rdy=%b want 0 0 0 1",
                         k, pdm_clk, pdm_data, underrun, pcm_if.pcm_ready);
            end
        end
    endtask

    task automatic test_clock_timing();
        logic prev_clk;
        logic prev_data;
        logic exp_clk;
        do_reset();
        pcm_if.pcm_data  = 16'h1234;
        pcm_if.pcm_valid = 1'b1;
        enable           = 1'b1;
        prev_clk         = pdm_clk;
        prev_data        = pdm_data;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            exp_clk = ((k % 4) >= 2);
            total += 2;
            if (pdm_clk !== exp_clk) begin
                bad++;
                $display("FAIL clk_pattern_%0d: got %b want %b",
                         k, pdm_clk, exp_clk);
            end
            if (pdm_data !== prev_data && !(prev_clk && !pdm_clk)) begin
                bad++;
                $display("FAIL data_edge_%0d: got change %b->%b want change only at pdm_clk fall",
                         k, prev_data, pdm_data);
            end
            prev_clk  = pdm_clk;
            prev_data = pdm_data;
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (pdm_clk !== 1'b0 || pdm_data !== 1'b0) begin
            bad++;
            $display("FAIL disable_clear: got clk=%b data=%b want 0 0",
                     pdm_clk, pdm_data);
        end
    endtask

    task automatic run_stream(input logic [15:0] val, input int lo,
                              input int hi, input string name);
        int   b;
        int   ones;
        int   urs;
        logic prev;
        do_reset();
        pcm_if.pcm_data  = val;
        pcm_if.pcm_valid = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        b      = 0;
        ones   = 0;
        urs    = 0;
        prev   = pdm_clk;
        for (int c = 0; c < 1000 && b < 193; c++) begin
            @(negedge clk);
            if (underrun) urs++;
            if (!prev && pdm_clk) begin
                if (b >= 129) ones += int'(pdm_data);
                b++;
            end
            prev = pdm_clk;
        end
        total += 3;
        if (b < 193) begin
            bad++;
            $display("FAIL %s_timeout: got %0d bits want 193", name, b);
        end
        if (ones < lo || ones > hi) begin
            bad++;
            $display("FAIL %s_density: got %0d ones want %0d..%0d",
                     name, ones, lo, hi);
        end
        if (urs != 0) begin
            bad++;
            $display("FAIL %s_underrun: got %0d pulses want 0", name, urs);
        end
    endtask

    task automatic test_density();
        run_stream(16'h0000, 30, 34, "zero");
        run_stream(16'h4000, 45, 51, "half_pos");
        run_stream(16'hC000, 13, 19, "half_neg");
    endtask

    task automatic test_backpressure();
        logic exp;
        do_reset();
        pcm_if.pcm_data  = 16'h0100;
        pcm_if.pcm_valid = 1'b1;
        #1;
        total++;
        if (pcm_if.pcm_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_0: got %b want 1", pcm_if.pcm_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp = (k < 2);
            total++;
            if (pcm_if.pcm_ready !== exp) begin
                bad++;
                $display("FAIL bp_fill_%0d: got %b want %b",
                         k, pcm_if.pcm_ready, exp);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp = (k == 4);
            total++;
            if (pcm_if.pcm_ready !== exp) begin
                bad++;
                $display("FAIL bp_drain_%0d: got %b want %b",
                         k, pcm_if.pcm_ready, exp);
            end
            if (k == 3) begin
                total++;
                if (underrun !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_underrun: got %b want 0", underrun);
                end
            end
        end
        enable           = 1'b0;
        pcm_if.pcm_valid = 1'b0;
    endtask

    task automatic test_underrun();
        int   b;
        int   ones;
        int   late;
        logic prev;
        logic exp;
        do_reset();
        enable = 1'b1;
        b      = 0;
        ones   = 0;
        prev   = pdm_clk;
        for (int k = 1; k <= 768; k++) begin
            @(negedge clk);
            exp = ((k % 256) == 3);
            total++;
            if (underrun !== exp) begin
                bad++;
                $display("FAIL ur_pulse_%0d: got %b want %b", k, underrun, exp);
            end
            if (!prev && pdm_clk) begin
                if (b >= 129 && b < 193) ones += int'(pdm_data);
                b++;
            end
            prev = pdm_clk;
        end
        total++;
        if (ones < 30 || ones > 34) begin
            bad++;
            $display("FAIL ur_density: got %0d ones want 30..34", ones);
        end
        pcm_if.pcm_data  = 16'h0000;
        pcm_if.pcm_valid = 1'b1;
        late             = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (underrun) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL ur_fed: got %0d pulses want 0", late);
        end
        enable           = 1'b0;
        pcm_if.pcm_valid = 1'b0;
    endtask

    task automatic test_full_scale_abort();
        int   v1;
        int   v2;
        logic exp;
        run_stream(16'h7FFF, 60, 64, "full_scale");
        v1 = int'(dut.i1);
        v2 = int'(dut.i2);
        total += 2;
        if (v1 > 262144 || v1 < -262144) begin
            bad++;
            $display("FAIL clamp_i1: got %0d want within +/-262144", v1);
        end
        if (v2 > 262144 || v2 < -262144) begin
            bad++;
            $display("FAIL clamp_i2: got %0d want within +/-262144", v2);
        end
        for (int c = 0; c < 8 && !pdm_clk; c++) @(negedge clk);
        pcm_if.pcm_valid = 1'b0;
        rst_n            = 1'b0;
        #1;
        total += 2;
        if (pdm_clk !== 1'b0 || pdm_data !== 1'b0 ||
            underrun !== 1'b0 || pcm_if.pcm_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_outputs: got clk=%b data=%b ur=%b rdy=%b want 0 0 0 1",
                     pdm_clk, pdm_data, underrun, pcm_if.pcm_ready);
        end
        if (int'(dut.i1) != 0 || int'(dut.i2) != 0) begin
            bad++;
            $display("FAIL abort_integ: got i1=%0d i2=%0d want 0 0",
                     int'(dut.i1), int'(dut.i2));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp = (k == 3);
            total++;
            if (underrun !== exp) begin
                bad++;
                $display("FAIL abort_restart_%0d: got %b want %b",
                         k, underrun, exp);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        enable           = 1'b0;
        pcm_if.pcm_valid = 1'b0;
        pcm_if.pcm_data  = 16'h0000;
        test_reset();
        test_clock_timing();
        test_density();
        test_backpressure();
        test_underrun();
        test_full_scale_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_modulator.md
PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: PCM sample width, signed two's complement.
REQ-002 SHALL provide parameter CLK_DIV, default 4: clk cycles per pdm_clk period; even, >= 2.
REQ-003 SHALL provide parameter OSR, default 64: PDM bits per PCM sample; power of two, >= 8.
REQ-004 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1: reset; asynchronous assertion, active-low.
REQ-006 SHALL provide port enable, input, 1: modulator run control.
REQ-007 SHALL provide port pcm_data, input, DATA_W: signed sample to transmit.
REQ-008 SHALL provide port pcm_valid, input, 1: pcm_data is valid.
REQ-009 SHALL provide port pcm_ready, output, 1: block accepts a sample this cycle.
REQ-010 SHALL provide port pdm_clk, output, 1: bit clock to the PDM receiver.
REQ-011 SHALL provide port pdm_data, output, 1: PDM bitstream.
REQ-012 SHALL provide port underrun, output, 1: one-cycle pulse when a sample is needed and none is buffered.

Function
REQ-013 Divider: counter div runs 0..CLK_DIV-1, wraps to 0; pdm_clk = 0 for div < CLK_DIV/2, else 1; pdm_clk is a registered output.
REQ-014 A bit tick SHALL occur on the cycle with enable=1 and div=CLK_DIV-1; pdm_data updates only on bit ticks, i.e. at the pdm_clk falling edge, and is stable across the rising edge.
REQ-015 Input buffer: 2-entry FIFO; pcm_ready = not full; push when pcm_valid and pcm_ready; no push when full, even if a pop occurs in the same cycle.
REQ-016 Bit counter bitcnt runs 0..OSR-1 and advances once per bit tick.
REQ-017 On a bit tick with bitcnt=0, the FIFO head SHALL be popped into cur_sample; if the FIFO is empty, cur_sample loads 0 and underrun pulses high for that cycle.
REQ-018 Modulator input x: the popped value (or 0) on bitcnt=0 ticks, else cur_sample; each sample therefore drives exactly OSR consecutive bits.
REQ-019 A push into an empty FIFO on the same cycle as a bitcnt=0 tick SHALL NOT bypass; the tick sees the FIFO as empty (underrun), and the sample is stored.
REQ-020 Modulator: second-order CIFB, integrators i1 and i2 each DATA_W+4 bits signed; fb = +2^(DATA_W-1) if the previous pdm_data = 1, else -2^(DATA_W-1).
REQ-021 Update on each bit tick: i1' = sat(i1 + x - fb); i2' = sat(i2 + i1' - fb); pdm_data' = (i2' >= 0).
REQ-022 sat() SHALL clamp to +/-2^(DATA_W+2); integrators SHALL NOT wrap.
REQ-023 With enable=0: div, bitcnt, i1, i2, cur_sample held at 0; pdm_clk = 0; pdm_data = 0; no underrun pulses; the FIFO keeps its contents and accepts pushes.
REQ-024 Deasserting enable mid-sample SHALL take effect the next cycle; on re-enable, operation restarts at div=0, bitcnt=0 with a FIFO pop.
REQ-025 Latency: a sample pushed at least one cycle before a bitcnt=0 tick SHALL modulate starting at that tick.

Reset
REQ-026 While rst_n = 0: div, bitcnt, i1, i2, cur_sample = 0; FIFO empty; pdm_clk = 0; pdm_data = 0; underrun = 0; pcm_ready = 1.
REQ-027 Reset asserted mid-sample SHALL discard FIFO contents and integrator state immediately; the first bit tick after release uses bitcnt=0.

Verification
REQ-028 Reset/idle: rst_n low, then high with enable=0 for 20 cycles -> pdm_clk = 0, pdm_data = 0, pcm_ready = 1, underrun never high.
REQ-029 Clock and data timing: enable=1, CLK_DIV=4 -> pdm_clk pattern 0,0,1,1 repeating; pdm_data changes only on cycles where pdm_clk falls.
REQ-030 Density: stream 0x0000 continuously -> after 2 samples of settling, 32 +/- 2 ones per 64 bits; stream 0x4000 -> 48 +/- 3 ones; stream 0xC000 -> 16 +/- 3 ones.
REQ-031 Backpressure: hold pcm_valid=1 with enable=0 -> two accepts, then pcm_ready = 0; after enable, the first pop reasserts pcm_ready the next cycle.
REQ-032 Underrun: enable with the FIFO empty -> underrun pulse on the first tick (bitcnt=0) and again every 64 ticks; ones density 32 +/- 2; no pulse once the FIFO is fed ahead.
REQ-033 Full-scale and abort: stream 0x7FFF -> >= 60 ones per 64 bits and integrators at no more than the clamp limits; assert rst_n low mid-sample -> all outputs at reset values the same cycle.
